// File: rtl/tdm_pkg.sv
// Shared TDM definitions for the demultiplexer and the future TDM mux/transmitter.
// Covers the slot count, the slot index width, the lock FSM encoding and a slot decoder.
package tdm_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } tdm_state_e;

  // One-hot channel select for a slot index.
  function automatic logic [NUM_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] slot);
    logic [NUM_SLOTS-1:0] sel;
    sel = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot;
    return sel;
  endfunction

endpackage

// File: rtl/tdm_slot_ctrl.sv
// Frame alignment control for the TDM demux: lock FSM, next-expected-slot counter and frame-good flag.
// Emits a combinational channel write-enable plus registered frame_valid / sync_err / locked.
module tdm_slot_ctrl
  import tdm_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic                 in_sof,
  output logic [NUM_SLOTS-1:0] wr_en,
  output logic                 frame_valid,
  output logic                 sync_err,
  output logic                 locked
);

  tdm_state_e           state_r;
  tdm_state_e           state_nxt_s;
  logic [SLOT_W-1:0]    slot_r;
  logic [SLOT_W-1:0]    slot_nxt_s;
  logic                 fgood_r;
  logic                 fgood_nxt_s;
  logic                 frame_valid_r;
  logic                 frame_valid_nxt_s;
  logic                 sync_err_r;
  logic                 sync_err_nxt_s;
  logic [NUM_SLOTS-1:0] wr_en_s;

  // State, slot counter, frame-good flag and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= HUNT;
      slot_r        <= {SLOT_W{1'b0}};
      fgood_r       <= 1'b0;
      frame_valid_r <= 1'b0;
      sync_err_r    <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      slot_r        <= slot_nxt_s;
      fgood_r       <= fgood_nxt_s;
      frame_valid_r <= frame_valid_nxt_s;
      sync_err_r    <= sync_err_nxt_s;
    end
  end

  // Next-state, slot advance and channel steering for an accepted beat.
  always_comb begin
    state_nxt_s       = state_r;
    slot_nxt_s        = slot_r;
    fgood_nxt_s       = fgood_r;
    frame_valid_nxt_s = 1'b0;
    sync_err_nxt_s    = 1'b0;
    wr_en_s           = {NUM_SLOTS{1'b0}};
    if (in_valid) begin
      case (state_r)
        HUNT: begin
          if (in_sof) begin
            wr_en_s     = slot_onehot(2'd0);
            state_nxt_s = LOCK;
            slot_nxt_s  = 2'd1;
            fgood_nxt_s = 1'b1;
          end else begin
            state_nxt_s = HUNT;
          end
        end
        LOCK: begin
          if (in_sof) begin
            // An SOF anywhere but slot 0 abandons the partial frame and restarts at slot 0.
            sync_err_nxt_s = (slot_r != 2'd0);
            wr_en_s        = slot_onehot(2'd0);
            slot_nxt_s     = 2'd1;
            fgood_nxt_s    = 1'b1;
          end else if (slot_r == 2'd0) begin
            sync_err_nxt_s = 1'b1;
            state_nxt_s    = HUNT;
            fgood_nxt_s    = 1'b0;
          end else begin
            wr_en_s           = slot_onehot(slot_r);
            slot_nxt_s        = slot_r + 2'd1;
            frame_valid_nxt_s = (slot_r == 2'd3) && fgood_r;
          end
        end
        default: begin
          state_nxt_s = HUNT;
          slot_nxt_s  = 2'd0;
          fgood_nxt_s = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  assign wr_en       = wr_en_s;
  assign frame_valid = frame_valid_r;
  assign sync_err    = sync_err_r;
  assign locked      = (state_r == LOCK);

endmodule

// File: rtl/tdm_demux_4ch.sv
// Four-channel TDM demultiplexer: steers slot-interleaved beats into four held channel registers.
// Alignment tracking lives in tdm_slot_ctrl; this level owns the channel data and valid pulses.
module tdm_demux_4ch
  import tdm_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  output logic [3:0]        out_valid,
  output logic              frame_valid,
  output logic              locked,
  output logic              sync_err
);

  logic [NUM_SLOTS-1:0] wr_en_s;
  logic [NUM_SLOTS-1:0] out_valid_r;
  logic [DATA_W-1:0]    ch_data_r [NUM_SLOTS];

  tdm_slot_ctrl u_slot_ctrl (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .wr_en       (wr_en_s),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  // Channel data registers hold their last value; out_valid mirrors the write for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= {NUM_SLOTS{1'b0}};
      for (int i = 0; i < NUM_SLOTS; i++) begin
        ch_data_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      out_valid_r <= wr_en_s;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (wr_en_s[i]) begin
          ch_data_r[i] <= in_data;
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data0 = ch_data_r[0];
  assign out_data1 = ch_data_r[1];
  assign out_data2 = ch_data_r[2];
  assign out_data3 = ch_data_r[3];

endmodule

// File: tb/tb_tdm_demux_4ch.sv
// Directed and randomized bench for tdm_demux_4ch against a slot-rule reference model.
module tb_tdm_demux_4ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_sof = 1'b0;
  logic [7:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0] out_valid;
  logic       frame_valid, locked, sync_err;

  int tests = 0;
  int failed = 0;

  // reference model state
  bit       m_locked;
  int       m_slot;
  bit       m_fgood;
  bit [7:0] m_ch [4];
  bit [3:0] e_valid;
  bit       e_fv, e_se;

  tdm_demux_4ch #(.DATA_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof),
    .out_data0(out_data0), .out_data1(out_data1), .out_data2(out_data2), .out_data3(out_data3),
    .out_valid(out_valid), .frame_valid(frame_valid), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"},  {28'd0, out_valid}, {28'd0, e_valid});
    check({tag, ".d0"},     {24'd0, out_data0}, {24'd0, m_ch[0]});
    check({tag, ".d1"},     {24'd0, out_data1}, {24'd0, m_ch[1]});
    check({tag, ".d2"},     {24'd0, out_data2}, {24'd0, m_ch[2]});
    check({tag, ".d3"},     {24'd0, out_data3}, {24'd0, m_ch[3]});
    check({tag, ".frame"},  {31'd0, frame_valid}, {31'd0, e_fv});
    check({tag, ".locked"}, {31'd0, locked}, {31'd0, m_locked});
    check({tag, ".syncerr"},{31'd0, sync_err}, {31'd0, e_se});
  endtask

  task automatic model_reset();
    m_locked = 1'b0; m_slot = 0; m_fgood = 1'b0;
    for (int i = 0; i < 4; i++) m_ch[i] = 8'h00;
    e_valid = 4'b0000; e_fv = 1'b0; e_se = 1'b0;
  endtask

  task automatic deliver(input int ch, input bit [7:0] d);
    m_ch[ch] = d;
    e_valid[ch] = 1'b1;
  endtask

  // Expected outputs one cycle after a beat, following the slot rules.
  task automatic model_step(input bit v, input bit sof, input bit [7:0] d);
    e_valid = 4'b0000; e_fv = 1'b0; e_se = 1'b0;
    if (v) begin
      if (!m_locked) begin
        if (sof) begin deliver(0, d); m_locked = 1'b1; m_slot = 1; m_fgood = 1'b1; end
      end else if (sof) begin
        if (m_slot != 0) e_se = 1'b1;
        deliver(0, d); m_slot = 1; m_fgood = 1'b1;
      end else if (m_slot == 0) begin
        e_se = 1'b1; m_locked = 1'b0; m_fgood = 1'b0;
      end else begin
        deliver(m_slot, d);
        if (m_slot == 3 && m_fgood) e_fv = 1'b1;
        m_slot = (m_slot + 1) % 4;
      end
    end
  endtask

  task automatic beat(input bit v, input bit sof, input bit [7:0] d, input string tag);
    in_valid = v; in_sof = sof; in_data = d;
    @(posedge clk);
    model_step(v, sof, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0; in_sof = 1'b0; in_data = 8'h00;
    rst = 1'b1;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic frame(input bit [7:0] base, input int gap, input string tag);
    for (int s = 0; s < 4; s++) begin
      beat(1'b1, s == 0, base + 8'(s), tag);
      for (int g = 0; g < gap; g++) beat(1'b0, 1'b0, 8'hEE, {tag, ".gap"});
    end
  endtask

  initial begin
    int stim_slot;
    bit v, sof;
    model_reset();
    #12;
    do_reset("reset");

    frame(8'hA0, 0, "frame_b2b");
    beat(1'b0, 1'b0, 8'h00, "idle");
    frame(8'h30, 1, "frame_gap1");
    frame(8'h40, 3, "frame_gap3");

    do_reset("reset2");
    beat(1'b1, 1'b0, 8'h11, "nosof1");
    beat(1'b1, 1'b0, 8'h22, "nosof2");

    frame(8'hC0, 0, "lock_again");
    beat(1'b1, 1'b1, 8'h10, "pre_resync_s0");
    beat(1'b1, 1'b0, 8'h11, "pre_resync_s1");
    beat(1'b1, 1'b1, 8'h55, "resync");
    beat(1'b1, 1'b0, 8'h56, "resync_s1");
    beat(1'b1, 1'b0, 8'h57, "resync_s2");
    beat(1'b1, 1'b0, 8'h58, "resync_s3");
    beat(1'b1, 1'b0, 8'h77, "missing_sof");
    beat(1'b0, 1'b0, 8'h00, "after_drop");

    beat(1'b1, 1'b1, 8'h90, "mid_s0");
    beat(1'b1, 1'b0, 8'h91, "mid_s1");
    beat(1'b1, 1'b0, 8'h92, "mid_s2");
    // asynchronous reset asserted away from any clock edge
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    beat(1'b0, 1'b0, 8'h00, "post_rst");
    frame(8'hD0, 0, "post_rst_frame");

    stim_slot = 0;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 3) != 0);
      sof = (stim_slot == 0);
      if ($urandom_range(0, 11) == 0) sof = ~sof;
      beat(v, sof, 8'($urandom), "random");
      if (v) stim_slot = sof ? 1 : (stim_slot + 1) % 4;
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
